// File: rtl/pdu_mem_ctrl_if.sv
// Host-side command / write-data / response bundle for pdu_mem_ctrl.
// master = host, slave = controller.
interface pdu_mem_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic        cmd_sel;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wdat_valid;
    logic        wdat_ready;
    logic [31:0] wdat;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_last;

    modport master (
        output cmd_valid, cmd_wr, cmd_sel, cmd_addr, cmd_len,
        output wdat_valid, wdat, rsp_ready,
        input  cmd_ready, wdat_ready,
        input  rsp_valid, rsp_data, rsp_err, rsp_last
    );

    modport slave (
        input  cmd_valid, cmd_wr, cmd_sel, cmd_addr, cmd_len,
        input  wdat_valid, wdat, rsp_ready,
        output cmd_ready, wdat_ready,
        output rsp_valid, rsp_data, rsp_err, rsp_last
    );
endinterface

// File: rtl/pdu_mem_ctrl.sv
// PDU debug memory sequencer: host burst commands to word-level
// IMEM/DMEM ctrl-port accesses while the CPU is halted.
module pdu_mem_ctrl #(
    parameter int RD_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_global_en,
    pdu_mem_ctrl_if.slave bus,
    output logic [31:0] cpu_ctrl_imem_addr,
    output logic [31:0] cpu_ctrl_imem_wdata,
    output logic        cpu_ctrl_imem_we,
    input  logic [31:0] cpu_ctrl_imem_rdata,
    output logic [31:0] cpu_ctrl_dmem_addr,
    output logic [31:0] cpu_ctrl_dmem_wdata,
    output logic        cpu_ctrl_dmem_we,
    input  logic [31:0] cpu_ctrl_dmem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_WAIT,
        RD_RSP,
        ACK
    } state_t;

    state_t      state, nxt_state;
    logic        sel, nxt_sel;
    logic [31:0] addr, nxt_addr;
    logic [7:0]  len, nxt_len;
    logic [8:0]  cnt, nxt_cnt;
    logic [31:0] rdat, nxt_rdat;
    logic        err, nxt_err;
    logic [7:0]  lat, nxt_lat;

    logic        cmd_ready;
    logic        wdat_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_last;
    logic        imem_we;
    logic        dmem_we;
    logic        at_last;

    assign at_last = (cnt == {1'b0, len});

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel   <= 1'b0;
            addr  <= '0;
            len   <= '0;
            cnt   <= '0;
            rdat  <= '0;
            err   <= 1'b0;
            lat   <= '0;
        end else begin
            state <= nxt_state;
            sel   <= nxt_sel;
            addr  <= nxt_addr;
            len   <= nxt_len;
            cnt   <= nxt_cnt;
            rdat  <= nxt_rdat;
            err   <= nxt_err;
            lat   <= nxt_lat;
        end
    end

    always_comb begin
        nxt_state  = state;
        nxt_sel    = sel;
        nxt_addr   = addr;
        nxt_len    = len;
        nxt_cnt    = cnt;
        nxt_rdat   = rdat;
        nxt_err    = err;
        nxt_lat    = lat;
        cmd_ready  = 1'b0;
        wdat_ready = 1'b0;
        rsp_valid  = 1'b0;
        rsp_data   = '0;
        rsp_err    = 1'b0;
        rsp_last   = 1'b0;
        imem_we    = 1'b0;
        dmem_we    = 1'b0;

        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    nxt_sel  = bus.cmd_sel;
                    nxt_addr = bus.cmd_addr;
                    nxt_len  = bus.cmd_len;
                    nxt_cnt  = '0;
                    nxt_lat  = '0;
                    if (cpu_global_en || bus.cmd_addr[1:0] != 2'b00) begin
                        nxt_err   = 1'b1;
                        nxt_state = ACK;
                    end else begin
                        nxt_err   = 1'b0;
                        nxt_state = bus.cmd_wr ? WRITE : RD_WAIT;
                    end
                end
            end

            WRITE: begin
                // wdat_ready drops with cpu_global_en, so no write can slip through
                wdat_ready = ~cpu_global_en;
                if (cpu_global_en) begin
                    nxt_err   = 1'b1;
                    nxt_state = ACK;
                end else if (bus.wdat_valid) begin
                    imem_we  = ~sel;
                    dmem_we  = sel;
                    nxt_addr = addr + 32'd4;
                    nxt_cnt  = cnt + 9'd1;
                    if (at_last) begin
                        nxt_err   = 1'b0;
                        nxt_state = ACK;
                    end
                end
            end

            RD_WAIT: begin
                if (cpu_global_en) begin
                    nxt_err   = 1'b1;
                    nxt_state = ACK;
                end else if (lat == 8'(RD_LAT)) begin
                    nxt_rdat  = sel ? cpu_ctrl_dmem_rdata : cpu_ctrl_imem_rdata;
                    nxt_lat   = '0;
                    nxt_state = RD_RSP;
                end else begin
                    nxt_lat = lat + 8'd1;
                end
            end

            RD_RSP: begin
                rsp_valid = 1'b1;
                rsp_data  = rdat;
                rsp_last  = at_last;
                if (bus.rsp_ready) begin
                    if (at_last) begin
                        nxt_state = IDLE;
                    end else begin
                        nxt_addr  = addr + 32'd4;
                        nxt_cnt   = cnt + 9'd1;
                        nxt_state = RD_WAIT;
                    end
                end
            end

            ACK: begin
                rsp_valid = 1'b1;
                rsp_last  = 1'b1;
                rsp_data  = {23'b0, cnt};
                rsp_err   = err;
                if (bus.rsp_ready) begin
                    nxt_state = IDLE;
                end
            end

            default: nxt_state = IDLE;
        endcase
    end

    assign bus.cmd_ready  = cmd_ready;
    assign bus.wdat_ready = wdat_ready;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_data   = rsp_data;
    assign bus.rsp_err    = rsp_err;
    assign bus.rsp_last   = rsp_last;

    assign cpu_ctrl_imem_addr  = addr;
    assign cpu_ctrl_dmem_addr  = addr;
    assign cpu_ctrl_imem_wdata = (state == WRITE) ? bus.wdat : 32'd0;
    assign cpu_ctrl_dmem_wdata = (state == WRITE) ? bus.wdat : 32'd0;
    assign cpu_ctrl_imem_we    = imem_we;
    assign cpu_ctrl_dmem_we    = dmem_we;

endmodule

// File: tb/tb_pdu_mem_ctrl.sv
// Bench for pdu_mem_ctrl: command table plus corner sequences,
// with response and memory-write scoreboards.
module tb_pdu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_global_en;
    logic [31:0] imem_addr, imem_wdata, imem_rdata;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        imem_we, dmem_we;

    pdu_mem_ctrl_if bus ();

    pdu_mem_ctrl #(.RD_LAT(1)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .cpu_global_en       (cpu_global_en),
        .bus                 (bus.slave),
        .cpu_ctrl_imem_addr  (imem_addr),
        .cpu_ctrl_imem_wdata (imem_wdata),
        .cpu_ctrl_imem_we    (imem_we),
        .cpu_ctrl_imem_rdata (imem_rdata),
        .cpu_ctrl_dmem_addr  (dmem_addr),
        .cpu_ctrl_dmem_wdata (dmem_wdata),
        .cpu_ctrl_dmem_we    (dmem_we),
        .cpu_ctrl_dmem_rdata (dmem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories, one edge of latency.
    logic [31:0] mem_i [256];
    logic [31:0] mem_d [256];
    always @(posedge clk) begin
        if (imem_we) mem_i[imem_addr[9:2]] <= imem_wdata;
        if (dmem_we) mem_d[dmem_addr[9:2]] <= dmem_wdata;
        imem_rdata <= mem_i[imem_addr[9:2]];
        dmem_rdata <= mem_d[dmem_addr[9:2]];
    end

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic        last;
    } rsp_t;

    typedef struct packed {
        logic        sel;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic        wr;
        logic        sel;
        logic [31:0] addr;
        logic [7:0]  len;
        logic        en;
        logic [31:0] d0;
        logic [31:0] step;
    } vec_t;

    rsp_t exp_rsp[$];
    wr_t  exp_wr[$];
    logic [31:0] sh_i [256];
    logic [31:0] sh_d [256];

    int checks   = 0;
    int failures = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_rsp.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = exp_rsp.pop_front();
                chk("rsp_data", bus.rsp_data, e.data);
                chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                chk("rsp_last", 32'(bus.rsp_last), 32'(e.last));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && (imem_we || dmem_we)) begin
            if (imem_we && dmem_we) chk("we_both", 32'd1, 32'd0);
            if (exp_wr.size() == 0) begin
                chk("we_unexpected", 32'd1, 32'd0);
            end else begin
                wr_t w;
                w = exp_wr.pop_front();
                chk("we_sel", 32'(dmem_we), 32'(w.sel));
                chk("we_addr", dmem_we ? dmem_addr : imem_addr, w.addr);
                chk("we_data", dmem_we ? dmem_wdata : imem_wdata, w.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(logic wr, logic sel, logic [31:0] a, logic [7:0] l);
        int n;
        bus.cmd_wr    = wr;
        bus.cmd_sel   = sel;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        bus.cmd_valid = 1'b1;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (bus.cmd_ready) break;
            n++;
            if (n > 100) begin
                chk("cmd_timeout", 32'd1, 32'd0);
                break;
            end
        end
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_word(logic [31:0] d);
        int n;
        bus.wdat       = d;
        bus.wdat_valid = 1'b1;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (bus.wdat_ready) break;
            n++;
            if (n > 100) begin
                chk("wdat_timeout", 32'd1, 32'd0);
                break;
            end
        end
        step();
        bus.wdat_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_rsp.size() != 0 || exp_wr.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_rsp.size() != 0 || exp_wr.size() != 0) begin
            chk("drain_timeout", 32'(exp_rsp.size() + exp_wr.size()), 32'd0);
            exp_rsp.delete();
            exp_wr.delete();
        end
        step();
        step();
    endtask

    task automatic expect_write(logic sel, logic [31:0] a, logic [31:0] d);
        exp_wr.push_back('{sel: sel, addr: a, data: d});
        if (sel) sh_d[a[9:2]] = d;
        else     sh_i[a[9:2]] = d;
    endtask

    task automatic run_vec(vec_t v);
        logic [31:0] a;
        logic [31:0] d;
        if (v.en || v.addr[1:0] != 2'b00) begin
            exp_rsp.push_back('{data: 32'd0, err: 1'b1, last: 1'b1});
        end else if (v.wr) begin
            for (int i = 0; i <= int'(v.len); i++) begin
                a = v.addr + 32'(4 * i);
                expect_write(v.sel, a, v.d0 + 32'(i) * v.step);
            end
            exp_rsp.push_back('{data: 32'(v.len) + 32'd1, err: 1'b0, last: 1'b1});
        end else begin
            for (int i = 0; i <= int'(v.len); i++) begin
                a = v.addr + 32'(4 * i);
                d = v.sel ? sh_d[a[9:2]] : sh_i[a[9:2]];
                exp_rsp.push_back('{data: d, err: 1'b0, last: (i == int'(v.len))});
            end
        end
        cpu_global_en = v.en;
        send_cmd(v.wr, v.sel, v.addr, v.len);
        if (v.wr && !v.en && v.addr[1:0] == 2'b00) begin
            for (int i = 0; i <= int'(v.len); i++) begin
                send_word(v.d0 + 32'(i) * v.step);
            end
        end
        drain();
        cpu_global_en = 1'b0;
    endtask

    vec_t vecs [10];

    initial begin
        int n;
        logic [31:0] held;

        rst            = 1'b1;
        cpu_global_en  = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_wr     = 1'b0;
        bus.cmd_sel    = 1'b0;
        bus.cmd_addr   = '0;
        bus.cmd_len    = '0;
        bus.wdat_valid = 1'b0;
        bus.wdat       = '0;
        bus.rsp_ready  = 1'b1;
        for (int i = 0; i < 256; i++) begin
            sh_i[i] = '0;
            sh_d[i] = '0;
        end

        vecs[0] = '{1'b1, 1'b0, 32'h0000_0000, 8'd3, 1'b0, 32'h1, 32'h1};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 8'd1, 1'b0, 32'hAA, 32'h11};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0020, 8'd2, 1'b1, 32'h77, 32'h1};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0002, 8'd0, 1'b0, 32'h99, 32'h1};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0101, 8'd0, 1'b0, 32'h0, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0000, 8'd3, 1'b0, 32'h0, 32'h0};
        vecs[6] = '{1'b1, 1'b1, 32'h0000_0400, 8'd9, 1'b0, 32'hDEAD_0000, 32'h1000};
        vecs[7] = '{1'b0, 1'b1, 32'h0000_0400, 8'd9, 1'b0, 32'h0, 32'h0};
        vecs[8] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 8'd1, 1'b0, 32'h5555, 32'h1111};
        vecs[9] = '{1'b0, 1'b0, 32'h0000_0020, 8'd0, 1'b1, 32'h0, 32'h0};

        step();
        step();
        @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_wdat_ready", 32'(bus.wdat_ready), 32'd0);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_dmem_we", 32'(dmem_we), 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // First read response lands RD_LAT+2 cycles after cmd fire.
        exp_rsp.push_back('{data: 32'hAA, err: 1'b0, last: 1'b0});
        exp_rsp.push_back('{data: 32'hBB, err: 1'b0, last: 1'b1});
        send_cmd(1'b0, 1'b1, 32'h0000_0100, 8'd1);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (bus.rsp_valid) break;
        end
        chk("rd_latency", 32'(n), 32'd3);
        drain();

        // Write aborted by the CPU taking memory after three words.
        for (int i = 0; i < 3; i++) expect_write(1'b1, 32'h300 + 32'(4 * i), 32'hC0 + 32'(i));
        exp_rsp.push_back('{data: 32'd3, err: 1'b1, last: 1'b1});
        send_cmd(1'b1, 1'b1, 32'h0000_0300, 8'd7);
        for (int i = 0; i < 3; i++) send_word(32'hC0 + 32'(i));
        cpu_global_en  = 1'b1;
        bus.wdat       = 32'hC3;
        bus.wdat_valid = 1'b1;
        @(negedge clk);
        chk("abort_wdat_ready", 32'(bus.wdat_ready), 32'd0);
        chk("abort_dmem_we", 32'(dmem_we), 32'd0);
        drain();
        cpu_global_en  = 1'b0;
        bus.wdat_valid = 1'b0;
        step();

        // Wrapping read with the host stalling the first response.
        exp_rsp.push_back('{data: 32'h5555, err: 1'b0, last: 1'b0});
        exp_rsp.push_back('{data: 32'h6666, err: 1'b0, last: 1'b1});
        bus.rsp_ready = 1'b0;
        send_cmd(1'b0, 1'b0, 32'hFFFF_FFFC, 8'd1);
        n = 0;
        while (n < 20 && !bus.rsp_valid) begin
            @(negedge clk);
            n++;
        end
        held = bus.rsp_data;
        chk("stall_first_data", held, 32'h5555);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
            chk("stall_data", bus.rsp_data, held);
        end
        step();
        bus.rsp_ready = 1'b1;
        n = 0;
        while (n < 20 && imem_addr != 32'd0) begin
            @(negedge clk);
            n++;
        end
        chk("wrap_addr", imem_addr, 32'd0);
        drain();

        // Reset in the middle of a write burst.
        expect_write(1'b0, 32'h40, 32'hE0);
        expect_write(1'b0, 32'h44, 32'hE1);
        send_cmd(1'b1, 1'b0, 32'h0000_0040, 8'd5);
        send_word(32'hE0);
        send_word(32'hE1);
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("midrst_imem_we", 32'(imem_we), 32'd0);
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_writes", 32'(exp_wr.size()), 32'd0);
        step();
        rst = 1'b0;
        repeat (5) step();
        run_vec('{1'b0, 1'b0, 32'h0000_0040, 8'd1, 1'b0, 32'h0, 32'h0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
